// File: rtl/add_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | add_seq_ctrl_if : operand/result handshake bundle for add_seq_ctrl |
// | Optional ovf signal exists when ADD_SEQ_OVF_EN is defined.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface add_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             busy;
`ifdef ADD_SEQ_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, res, cout, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, res, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, res, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, res, cout, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | add_seq_ctrl : nibble-serial WIDTH-bit adder around one 4-bit CLA  |
// | slice. ADD_SEQ_OVF_EN adds a registered two's-complement ovf flag. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module add_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int c_nib = WIDTH / 4;
  localparam int c_kw  = (c_nib > 1) ? $clog2(c_nib) : 1;
  localparam logic [c_kw-1:0] c_klast = c_kw'(c_nib - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_bad
    $error("add_seq_ctrl: WIDTH=%0d must be a multiple of 4 and >= 4", WIDTH);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;
  logic [c_kw-1:0]  r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [3:0] w_na, w_nb, w_g, w_p, w_sum;
  logic [4:0] w_c;

  // r_live holds in_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  assign w_in_ready = r_live &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && w_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_k == c_klast) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single 4-bit carry-lookahead slice, fed the current nibble pair
  assign w_na   = r_a[4*r_k +: 4];
  assign w_nb   = r_b[4*r_k +: 4];
  assign w_g    = w_na & w_nb;
  assign w_p    = w_na ^ w_nb;
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_sum  = w_p ^ w_c[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_k     <= '0;
    end else if (w_step) begin
      r_res[4*r_k +: 4] <= w_sum;
      r_carry           <= w_c[4];
      if (w_last) r_cout <= w_c[4];
      else        r_k    <= r_k + c_kw'(1);
    end
  end

`ifdef ADD_SEQ_OVF_EN
  logic r_ovf;

  // Overflow is the carry into the MSB xor the carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ovf <= 1'b0;
    else if (w_step && w_last) r_ovf <= w_c[3] ^ w_c[4];
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_RUN);
  assign bus.res       = r_res;
  assign bus.cout      = r_cout;

endmodule
`default_nettype wire
